// File: rtl/divisor_secuencial_if.sv
// ---------------------------------------------------------------------------
// divisor_secuencial_if
// Purpose : groups the start/done control and operand/result buses of the
//           sequential divider so they travel as a single port.
// Signals : start  - request a division (master -> slave)
//           D, V   - dividend / divisor, N bits (master -> slave)
//           Q, R   - quotient / remainder, N bits (slave -> master)
//           busy   - division in progress (slave -> master)
//           done   - one-cycle result-valid pulse (slave -> master)
//           div0   - last accepted divisor was zero (slave -> master)
// Modports: master (requester side), slave (divider side).
// ---------------------------------------------------------------------------
interface divisor_secuencial_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] D;
    logic [N-1:0] V;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         div0;

    modport master (
        output start, D, V,
        input  Q, R, busy, done, div0
    );

    modport slave (
        input  start, D, V,
        output Q, R, busy, done, div0
    );
endinterface

// File: rtl/divisor_secuencial.sv
// ---------------------------------------------------------------------------
// divisor_secuencial
// Purpose : sequential restoring (shift-subtract) divider, Q = D / V and
//           R = D % V, producing one quotient bit per clock. The FSM
//           controller and the datapath both live here.
// Ports   : clk   - single clock, rising edge
//           reset - synchronous, active-high; wins over start
//           bus   - divisor_secuencial_if.slave (start, D, V in;
//                   Q, R, busy, done, div0 out)
// Config  : DIVISOR_SIGNED_EN - when defined, D and V are two's complement;
//           magnitudes are divided and the signs applied on completion
//           (quotient truncates toward zero, remainder follows dividend).
//           When undefined the divider is purely unsigned.
// ---------------------------------------------------------------------------
module divisor_secuencial #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    divisor_secuencial_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  qs_q, qs_d;     // quotient shift register (starts as dividend)
    logic [N-1:0]  vs_q, vs_d;     // captured divisor
    // After every restoring step the partial remainder is below the divisor,
    // so its top bit is always zero between steps and need not be stored.
    logic [N-1:0]  pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          div0_q, div0_d;

    logic [N:0]    pr_shift;
    logic [N:0]    trial;
    logic [N-1:0]  qs_step;
    logic [N-1:0]  pr_step;
    logic [N-1:0]  q_final;
    logic [N-1:0]  r_final;
    logic [N-1:0]  d_mag;
    logic [N-1:0]  v_mag;
    logic          accept;

`ifdef DIVISOR_SIGNED_EN
    logic          sd_q, sd_d;
    logic          sv_q, sv_d;
`endif

    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // One restoring step: shift in the next dividend bit, try a subtract,
    // keep the difference only if it did not borrow.
    always_comb begin
        pr_shift = {pr_q, qs_q[N-1]};
        trial    = pr_shift - {1'b0, vs_q};
        if (trial[N] == 1'b0) begin
            pr_step = trial[N-1:0];
            qs_step = {qs_q[N-2:0], 1'b1};
        end else begin
            pr_step = pr_shift[N-1:0];
            qs_step = {qs_q[N-2:0], 1'b0};
        end
    end

    // Operand magnitudes and final sign correction.
    always_comb begin
        d_mag   = bus.D;
        v_mag   = bus.V;
        q_final = qs_step;
        r_final = pr_step;
`ifdef DIVISOR_SIGNED_EN
        if (bus.D[N-1]) d_mag = -bus.D;
        if (bus.V[N-1]) v_mag = -bus.V;
        if (sd_q ^ sv_q) q_final = -qs_step;
        if (sd_q)        r_final = -pr_step;
`endif
    end

    always_comb begin
        state_d = state_q;
        qs_d    = qs_q;
        vs_d    = vs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
`ifdef DIVISOR_SIGNED_EN
        sd_d    = sd_q;
        sv_d    = sv_q;
`endif
        if (accept) begin
            qs_d   = d_mag;
            vs_d   = v_mag;
            pr_d   = '0;
            cnt_d  = '0;
            div0_d = (bus.V == '0);
`ifdef DIVISOR_SIGNED_EN
            sd_d   = bus.D[N-1];
            sv_d   = bus.V[N-1];
`endif
            if (bus.V == '0) begin
                // Zero divisor: skip the core and report straight away.
                state_d = ST_DONE;
                q_d     = '1;
                r_d     = bus.D;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    qs_d  = qs_step;
                    pr_d  = pr_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_DONE;
                        q_d     = q_final;
                        r_d     = r_final;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            qs_q    <= '0;
            vs_q    <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            qs_q    <= qs_d;
            vs_q    <= vs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
`ifdef DIVISOR_SIGNED_EN
            sd_q    <= sd_d;
            sv_q    <= sv_d;
`endif
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_divisor_secuencial.sv
// ---------------------------------------------------------------------------
// tb_divisor_secuencial
// Purpose : directed self-checking bench for divisor_secuencial (N = 8).
//           Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_divisor_secuencial;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;
    int   bcnt;
    int   seen_done;

    divisor_secuencial_if #(.N(8)) bus ();

    divisor_secuencial #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [7:0] d, input logic [7:0] v);
        @(negedge clk);
        bus.D     = d;
        bus.V     = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Count falling edges (starting at 1 = cycle after accept) until done.
    task automatic wait_done(output int c, output int b);
        c = 1;
        b = 0;
        while (bus.done !== 1'b1 && c < 40) begin
            if (bus.busy === 1'b1) b++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] d, input logic [7:0] v,
                             input logic [7:0] eq, input logic [7:0] er,
                             input logic ediv0, input int ecyc);
        start_op(d, v);
        wait_done(cyc, bcnt);
        $display("op %s: D=%0d V=%0d -> Q=%0h R=%0h div0=%0b after %0d cycles",
                 tag, d, v, bus.Q, bus.R, bus.div0, cyc);
        check({tag, "_lat"},  cyc,      ecyc);
        check({tag, "_Q"},    bus.Q,    eq);
        check({tag, "_R"},    bus.R,    er);
        check({tag, "_div0"}, bus.div0, ediv0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        bus.start = 1'b0;
        bus.D     = '0;
        bus.V     = '0;

        // T1: reset for two cycles
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_Q",    bus.Q,    8'd0);
        check("rst_R",    bus.R,    8'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div0", bus.div0, 1'b0);

        // T2: 100 / 7, busy for 8 cycles, done on cycle 9
        start_op(8'd100, 8'd7);
        bus.D = 8'd0;             // operands may change after the accept edge
        bus.V = 8'd0;
        wait_done(cyc, bcnt);
        $display("op t2: D=100 V=7 -> Q=%0d R=%0d after %0d cycles", bus.Q, bus.R, cyc);
        check("t2_lat",  cyc,      9);
        check("t2_busy", bcnt,     8);
        check("t2_Q",    bus.Q,    8'd14);
        check("t2_R",    bus.R,    8'd2);
        check("t2_div0", bus.div0, 1'b0);
        check("t2_busy_in_done", bus.busy, 1'b0);
        @(negedge clk);
        check("t2_done_pulse", bus.done, 1'b0);
        check("t2_Q_hold",     bus.Q,    8'd14);

        // T3: divide by zero, then a clean divide
        run_check("t3_v0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);
        @(negedge clk);
        check("t3_div0_hold", bus.div0, 1'b1);
        run_check("t3_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);

        // T4 and boundaries
        run_check("t4_max", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
        run_check("t4_lt",  8'd3,   8'd10,  8'd0, 8'd3, 1'b0, 9);
        run_check("d_zero", 8'd0,   8'd5,   8'd0, 8'd0, 1'b0, 9);
        run_check("v_one",  8'd200, 8'd1,   8'd200, 8'd0, 1'b0, 9);

        // Back-to-back: start asserted in the DONE cycle
        start_op(8'd50, 8'd6);
        wait_done(cyc, bcnt);
        check("b2b_first_Q", bus.Q, 8'd8);
        check("b2b_first_R", bus.R, 8'd2);
        bus.D     = 8'd77;
        bus.V     = 8'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        wait_done(cyc, bcnt);
        $display("op b2b: D=77 V=5 -> Q=%0d R=%0d after %0d cycles", bus.Q, bus.R, cyc);
        check("b2b_lat", cyc,   9);
        check("b2b_Q",   bus.Q, 8'd15);
        check("b2b_R",   bus.R, 8'd2);

        // T5a: start mid-RUN is ignored
        start_op(8'd100, 8'd7);
        @(negedge clk);
        @(negedge clk);
        bus.D     = 8'd50;
        bus.V     = 8'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_still_busy", bus.busy, 1'b1);
        cyc = 4;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        $display("op t5_ign: D=100 V=7 -> Q=%0d R=%0d after %0d cycles", bus.Q, bus.R, cyc);
        check("t5_ign_lat", cyc,   9);
        check("t5_ign_Q",   bus.Q, 8'd14);
        check("t5_ign_R",   bus.R, 8'd2);
        @(negedge clk);
        check("t5_no_restart", bus.busy, 1'b0);

        // T5b: reset mid-RUN aborts with no done
        start_op(8'd200, 8'd9);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5r_busy", bus.busy, 1'b0);
        check("t5r_Q",    bus.Q,    8'd0);
        check("t5r_R",    bus.R,    8'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) seen_done++;
            @(negedge clk);
        end
        $display("op t5_rst: aborted, done pulses seen=%0d", seen_done);
        check("t5r_no_done", seen_done, 0);

`ifdef DIVISOR_SIGNED_EN
        // T6: signed operands
        run_check("t6_nd", 8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 9);
        run_check("t6_nv", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 9);
        run_check("t6_wrap", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
